clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter N_CH, default 2, number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of each half-period value and counter.
REQ-003 Parameter RST_HALF, default 2, half-period loaded into every channel at reset.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  N_CH  per-channel run enable.
REQ-007 half_per  input  N_CH*CNT_W  requested half-period in clk cycles; channel i in bits [i*CNT_W +: CNT_W].
REQ-008 load  input  N_CH  one-cycle strobe; captures the channel's half_per into its shadow register.
REQ-009 pending  output  N_CH  high while a captured value awaits application.
REQ-010 mclk  output  N_CH  divided clock, registered, 50% duty.
REQ-011 tick  output  N_CH  one-cycle pulse in the cycle mclk rises.

Function
REQ-012 Each channel SHALL hold active half-period H, shadow S, counter C (CNT_W bits), and mclk.
REQ-013 H=0 or S=0 SHALL be treated as 1 (clamp at capture); mclk period is 2*H clk cycles.
REQ-014 With en=1: if C==H-1 then C<=0 and mclk toggles, else C<=C+1.
REQ-015 tick SHALL be 1 in exactly the cycle in which mclk's registered value changes 0->1.
REQ-016 load=1 SHALL set S<=clamped half_per and pending<=1 on the next edge; a later load while pending overwrites S (last wins).
REQ-017 Period boundary = the edge where mclk toggles 1->0; at a boundary with pending=1, H<=S and pending<=0.
REQ-018 load coinciding with a boundary SHALL NOT apply at that boundary; new S applies at the next boundary, pending stays 1.
REQ-019 The change SHALL never produce a runt: every high/low phase lasts exactly the H in force when it began.
REQ-020 With en=0: C<=0, mclk<=0, tick=0; if pending, H<=S and pending<=0 immediately.
REQ-021 en 0->1 SHALL start a high phase: first toggle to 1 after H cycles, counted from the enabling edge.
REQ-022 Channels SHALL be fully independent; no cross-channel timing dependence.

Reset
REQ-023 rst_n=0 SHALL asynchronously force C=0, mclk=0, tick=0, pending=0, H=S=RST_HALF (clamped).
REQ-024 Reset mid-period or mid-pending SHALL discard the pending value; no output glitch on release.

Configuration
REQ-025 Macro CLK_DIV_TICK_EN defined: tick generated per REQ-015.
REQ-026 CLK_DIV_TICK_EN undefined: tick port present, tied to 0, no tick logic synthesised.

Structure
REQ-027 Package clk_div_pkg SHALL hold default CNT_W, default RST_HALF, and max N_CH constant.
REQ-028 Sub-module clk_div_ch SHALL implement one channel; clk_div_bank instantiates N_CH copies via generate.

Verification
REQ-029 Reset release, en=1, H=2 -> mclk period 4 clk, tick every 4 clk, pending=0.
REQ-030 Running H=2, load half_per=5 mid-high-phase -> current period completes at 4 clk, next periods 10 clk, pending drops at boundary.
REQ-031 load 3 then load 7 before boundary -> only H=7 applied, single pending window.
REQ-032 load coincident with 1->0 boundary -> old H used one more period, new H afterwards.
REQ-033 half_per=0 loaded -> period 2 clk, tick every 2 clk; en=0 mid-phase -> mclk=0 next edge, pending cleared.
REQ-034 rst_n asserted mid-period with pending=1 -> mclk=0 immediately, after release period 2*RST_HALF.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank.
package clk_div_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int RST_HALF_DEF = 2;
    localparam int N_CH_MAX     = 8;

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle for the divider bank; master drives, slave divides.
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = CNT_W_DEF
);

    logic [N_CH-1:0]       en;
    logic [N_CH*CNT_W-1:0] half_per;
    logic [N_CH-1:0]       load;
    logic [N_CH-1:0]       pending;
    logic [N_CH-1:0]       mclk;
    logic [N_CH-1:0]       tick;

    modport master (
        output en,
        output half_per,
        output load,
        input  pending,
        input  mclk,
        input  tick
    );

    modport slave (
        input  en,
        input  half_per,
        input  load,
        output pending,
        output mclk,
        output tick
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel with shadowed half-period, swapped only at the 1->0 edge.
// Tick pulse logic exists only when CLK_DIV_TICK_EN is defined.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RST_HALF = RST_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] half_per,
    input  logic             load,
    output logic             pending,
    output logic             mclk,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_H =
        (RST_HALF == 0) ? CNT_W'(1) : CNT_W'(RST_HALF);

    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] s_q;
    logic [CNT_W-1:0] c_q;
    logic             p_q;
    logic             m_q;
    logic [CNT_W-1:0] hp_c;
    logic             wrap;
    logic             bnd;
    logic             swap;

    assign hp_c = (half_per == '0) ? CNT_W'(1) : half_per;
    assign wrap = (c_q == h_q - CNT_W'(1));
    assign bnd  = en & wrap & m_q;
    // Disabled channels take the shadow at once; running ones wait for 1->0.
    assign swap = bnd | ~en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= RST_H;
            s_q <= RST_H;
            c_q <= '0;
            p_q <= 1'b0;
            m_q <= 1'b0;
        end else begin
            if (en) begin
                c_q <= wrap ? '0 : c_q + CNT_W'(1);
                if (wrap) m_q <= ~m_q;
            end else begin
                c_q <= '0;
                m_q <= 1'b0;
            end
            if (p_q && swap) h_q <= s_q;
            if (load) begin
                s_q <= hp_c;
                p_q <= 1'b1;
            end else if (swap) begin
                p_q <= 1'b0;
            end
        end
    end

    assign pending = p_q;
    assign mclk    = m_q;

`ifdef CLK_DIV_TICK_EN
    logic t_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) t_q <= 1'b0;
        else        t_q <= en & wrap & ~m_q;
    end

    assign tick = t_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent glitch-free clock dividers.
// Define CLK_DIV_TICK_EN to generate the per-channel rising-edge tick.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RST_HALF = RST_HALF_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_bank_if.slave  bus
);

    logic [N_CH-1:0] pend_w;
    logic [N_CH-1:0] mclk_w;
    logic [N_CH-1:0] tick_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W    (CNT_W),
            .RST_HALF (RST_HALF)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (bus.en[i]),
            .half_per (bus.half_per[i*CNT_W +: CNT_W]),
            .load     (bus.load[i]),
            .pending  (pend_w[i]),
            .mclk     (mclk_w[i]),
            .tick     (tick_w[i])
        );
    end

    assign bus.pending = pend_w;
    assign bus.mclk    = mclk_w;
    assign bus.tick    = tick_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: sampled mclk/tick/pending bit strings.
module tb_clk_div_bank;

`ifdef CLK_DIV_TICK_EN
    localparam bit TK = 1'b1;
`else
    localparam bit TK = 1'b0;
`endif

    logic clk;
    logic rst_n;

    clk_div_bank_if #(.N_CH(2), .CNT_W(16)) bus ();

    clk_div_bank #(
        .N_CH     (2),
        .CNT_W    (16),
        .RST_HALF (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mv0, tv0, pv0, mv1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] tx(input logic [31:0] v);
        return TK ? v : 32'd0;
    endfunction

    task automatic clr();
        mv0 = '0;
        tv0 = '0;
        pv0 = '0;
        mv1 = '0;
    endtask

    task automatic tk();
        @(negedge clk);
        mv0 = {mv0[30:0], bus.mclk[0]};
        tv0 = {tv0[30:0], bus.tick[0]};
        pv0 = {pv0[30:0], bus.pending[0]};
        mv1 = {mv1[30:0], bus.mclk[1]};
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.en       = '0;
        bus.load     = '0;
        bus.half_per = '0;
        repeat (2) @(negedge clk);
        chk("rst_mclk", {30'b0, bus.mclk}, 32'd0);
        chk("rst_pend", {30'b0, bus.pending}, 32'd0);
        chk("rst_tick", {30'b0, bus.tick}, 32'd0);

        // H=2 from reset: period 4
        rst_n     = 1'b1;
        clr();
        bus.en[0] = 1'b1;
        repeat (8) tk();
        chk("t1_mclk", mv0, {24'b0, 8'b0110_0110});
        chk("t1_tick", tv0, tx({24'b0, 8'b0100_0100}));
        chk("t1_pend", pv0, 32'd0);
        chk("t1_ch1", mv1, 32'd0);

        // load 5 mid-high phase
        clr();
        tk();
        tk();
        bus.half_per[15:0] = 16'd5;
        bus.load[0]        = 1'b1;
        tk();
        bus.load[0] = 1'b0;
        repeat (21) tk();
        chk("t2_mclk", mv0, {8'b0, 24'b0110_0000_1111_1000_0011_1110});
        chk("t2_tick", tv0, tx({8'b0, 24'b0100_0000_1000_0000_0010_0000}));
        chk("t2_pend", pv0, {8'b0, 24'b0010_0000_0000_0000_0000_0000});

        // load 3 then 7 before boundary; ch1 started with H=3
        clr();
        bus.en[1]           = 1'b1;
        bus.half_per[31:16] = 16'd3;
        bus.load[1]         = 1'b1;
        tk();
        bus.load[1]        = 1'b0;
        bus.half_per[15:0] = 16'd3;
        bus.load[0]        = 1'b1;
        tk();
        bus.load[0] = 1'b0;
        repeat (4) tk();
        bus.half_per[15:0] = 16'd7;
        bus.load[0]        = 1'b1;
        tk();
        bus.load[0] = 1'b0;
        repeat (17) tk();
        chk("t3_mclk", mv0, {8'b0, 24'b0000_1111_1000_0000_1111_1110});
        chk("t3_tick", tv0, tx({8'b0, 24'b0000_1000_0000_0000_1000_0000}));
        chk("t3_pend", pv0, {8'b0, 24'b0111_1111_1000_0000_0000_0000});
        chk("t3_ch1", mv1, {8'b0, 1'b0, 2'b11, 3'b000, 3'b111, 3'b000,
                            3'b111, 3'b000, 3'b111, 3'b000});

        // load 2 coincident with the 1->0 boundary
        clr();
        repeat (13) tk();
        bus.half_per[15:0] = 16'd2;
        bus.load[0]        = 1'b1;
        tk();
        bus.load[0] = 1'b0;
        repeat (18) tk();
        chk("t4_mclk", mv0, {6'b0, 7'h7f, 7'h00, 7'h7f, 2'b00, 2'b11, 1'b0});
        chk("t4_tick", tv0, tx({6'b0, 1'b1, 13'b0, 1'b1, 8'b0, 1'b1, 2'b0}));
        chk("t4_pend", pv0, {13'b0, 14'h3fff, 5'b0});

        // half_per=0 clamps to 1
        clr();
        bus.half_per[15:0] = 16'd0;
        bus.load[0]        = 1'b1;
        tk();
        bus.load[0] = 1'b0;
        repeat (11) tk();
        chk("t5_mclk", mv0, {20'b0, 12'b0110_1010_1010});
        chk("t5_tick", tv0, tx({20'b0, 12'b0100_1010_1010}));
        chk("t5_pend", pv0, {20'b0, 12'b1110_0000_0000});

        // en=0 mid-high with pending: low next edge, H applied at once
        clr();
        bus.half_per[15:0] = 16'd5;
        bus.load[0]        = 1'b1;
        tk();
        bus.load[0] = 1'b0;
        bus.en[0]   = 1'b0;
        tk();
        bus.en[0] = 1'b1;
        repeat (6) tk();
        chk("t5b_mclk", mv0, {24'b0, 8'b1000_0011});
        chk("t5b_tick", tv0, tx({24'b0, 8'b1000_0010}));
        chk("t5b_pend", pv0, {24'b0, 8'b1000_0000});

        // async reset mid-period with pending
        clr();
        bus.half_per[15:0] = 16'd7;
        bus.load[0]        = 1'b1;
        tk();
        bus.load[0] = 1'b0;
        chk("t6_pre_pend", {31'b0, bus.pending[0]}, 32'd1);
        chk("t6_pre_mclk", {31'b0, bus.mclk[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_mclk", {30'b0, bus.mclk}, 32'd0);
        chk("t6_rst_pend", {30'b0, bus.pending}, 32'd0);
        chk("t6_rst_tick", {30'b0, bus.tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        repeat (8) tk();
        chk("t6_mclk", mv0, {24'b0, 8'b0110_0110});
        chk("t6_tick", tv0, tx({24'b0, 8'b0100_0100}));
        chk("t6_pend", pv0, 32'd0);
        chk("t6_ch1", mv1, {24'b0, 8'b0110_0110});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
